// File: rtl/rate_match_fifo.sv
// ---------------------------------------------------------------------------
// rate_match_fifo
//
// Synchronous FIFO that sits in the 100GbE PCS idle insertion/deletion path.
// The FIFO tracks exact occupancy, so the idle controller can use the
// threshold flags to decide when to delete or insert idles.
//
// Write and read requests are both qualified by the shared data-valid strobe.
// The read port is registered and has a one-cycle latency. Dropped writes
// and rejected reads are reported through sticky flags.
//
// Optional feature, enabled by the macro RATE_MATCH_FIFO_ERR_CNT_EN:
//   It adds o_drop_cnt and o_reject_cnt. These are saturating 16-bit event
//   counters that only i_reset clears.
//
// Ports:
//   i_clock         single clock
//   i_reset         synchronous active-high reset, highest priority
//   i_enable        block enable; low flushes pointers/count synchronously
//   i_valid         data-valid strobe, qualifies write and read requests
//   i_write_enb     write request
//   i_read_enb      read request
//   i_data          write data
//   o_data          registered read data (holds when no read is accepted)
//   o_rd_valid      o_data was updated by a read this cycle
//   o_count         occupancy 0..DEPTH
//   o_empty         count == 0
//   o_full          count == DEPTH
//   o_almost_full   count >= ALMOST_FULL_TH
//   o_almost_empty  count <= ALMOST_EMPTY_TH
//   o_overflow      sticky: a write was dropped
//   o_underflow     sticky: a read was rejected
//   o_drop_cnt      (optional) saturating count of dropped writes
//   o_reject_cnt    (optional) saturating count of rejected reads
// ---------------------------------------------------------------------------
module rate_match_fifo #(
  parameter int NB_DATA         = 72,
  parameter int NB_ADDR         = 5,
  parameter int ALMOST_FULL_TH  = (2**NB_ADDR) - 4,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic               i_write_enb,
  input  logic               i_read_enb,
  input  logic [NB_DATA-1:0] i_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rd_valid,
  output logic [NB_ADDR:0]   o_count,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_almost_full,
  output logic               o_almost_empty,
  output logic               o_overflow,
`ifdef RATE_MATCH_FIFO_ERR_CNT_EN
  output logic [15:0]        o_drop_cnt,
  output logic [15:0]        o_reject_cnt,
`endif
  output logic               o_underflow
);

  localparam int                 DEPTH   = 2**NB_ADDR;
  localparam logic [NB_ADDR:0]   DEPTH_C = (NB_ADDR+1)'(DEPTH);
  localparam logic [NB_ADDR:0]   AF_TH_C = (NB_ADDR+1)'(ALMOST_FULL_TH);
  localparam logic [NB_ADDR:0]   AE_TH_C = (NB_ADDR+1)'(ALMOST_EMPTY_TH);
  localparam logic [NB_ADDR-1:0] PTR_ONE = NB_ADDR'(1);
  localparam logic [NB_ADDR:0]   CNT_ONE = (NB_ADDR+1)'(1);

  // Storage is a plain array with a registered read, so it maps onto block RAM.
  logic [NB_DATA-1:0] mem [DEPTH];

  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [NB_ADDR:0]   count_q, count_d;
  logic [NB_DATA-1:0] data_q;
  logic               rd_valid_q;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic wr_req, rd_req, wr_acc, rd_acc;
  logic drop_evt, reject_evt;
  logic empty, full;

  // Full and empty come from the registered count only.
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  always_comb begin
    wr_req      = i_write_enb & i_valid;
    rd_req      = i_read_enb & i_valid;
    // A read is accepted whenever data is present. A write into a full FIFO
    // is still accepted if a read frees a slot in the same cycle.
    rd_acc      = i_enable & rd_req & ~empty;
    wr_acc      = i_enable & wr_req & (~full | rd_acc);
    // Error events are only counted while enabled. A disabled block accepts
    // nothing and leaves the sticky state alone.
    drop_evt    = i_enable & wr_req & ~wr_acc;
    reject_evt  = i_enable & rd_req & ~rd_acc;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | drop_evt;
    underflow_d = underflow_q | reject_evt;

    if (!i_enable) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // The memory write port has no reset. When the FIFO is full and both a
  // read and a write are accepted, the two pointers are equal. The read
  // below samples the old word in that same edge, so the new word cannot
  // corrupt the word being read.
  always_ff @(posedge i_clock) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      data_q <= '0;
    end else if (rd_acc) begin
      data_q <= mem[rd_ptr_q];
    end
  end

`ifdef RATE_MATCH_FIFO_ERR_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] reject_cnt_q, reject_cnt_d;

  always_comb begin
    drop_cnt_d   = drop_cnt_q;
    reject_cnt_d = reject_cnt_q;
    if (drop_evt && (drop_cnt_q != 16'hFFFF))     drop_cnt_d   = drop_cnt_q + 16'd1;
    if (reject_evt && (reject_cnt_q != 16'hFFFF)) reject_cnt_d = reject_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      drop_cnt_q   <= '0;
      reject_cnt_q <= '0;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign o_drop_cnt   = drop_cnt_q;
  assign o_reject_cnt = reject_cnt_q;
`endif

  assign o_data         = data_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_count        = count_q;
  assign o_empty        = empty;
  assign o_full         = full;
  assign o_almost_full  = (count_q >= AF_TH_C);
  assign o_almost_empty = (count_q <= AE_TH_C);
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_rate_match_fifo.sv
// ---------------------------------------------------------------------------
// tb_rate_match_fifo
//
// Directed and randomised bench for rate_match_fifo.
// The reference model is a queue of words plus the sticky and read-port
// state. After each clock, every DUT output is compared with that model.
// Build with RATE_MATCH_FIFO_ERR_CNT_EN defined to also cover the optional
// error counters.
// ---------------------------------------------------------------------------
module tb_rate_match_fifo;

  localparam int NB_DATA = 72;
  localparam int NB_ADDR = 5;
  localparam int DEPTH   = 2**NB_ADDR;
  localparam int AF_TH   = DEPTH - 4;
  localparam int AE_TH   = 4;

  logic               clk = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_enable = 1'b1;
  logic               i_valid = 1'b0;
  logic               i_write_enb = 1'b0;
  logic               i_read_enb = 1'b0;
  logic [NB_DATA-1:0] i_data = '0;
  logic [NB_DATA-1:0] o_data;
  logic               o_rd_valid;
  logic [NB_ADDR:0]   o_count;
  logic               o_empty, o_full, o_almost_full, o_almost_empty;
  logic               o_overflow, o_underflow;
`ifdef RATE_MATCH_FIFO_ERR_CNT_EN
  logic [15:0]        o_drop_cnt, o_reject_cnt;
`endif

  always #5 clk = ~clk;

  rate_match_fifo #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR)
  ) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_valid       (i_valid),
    .i_write_enb   (i_write_enb),
    .i_read_enb    (i_read_enb),
    .i_data        (i_data),
    .o_data        (o_data),
    .o_rd_valid    (o_rd_valid),
    .o_count       (o_count),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .o_almost_empty(o_almost_empty),
    .o_overflow    (o_overflow),
`ifdef RATE_MATCH_FIFO_ERR_CNT_EN
    .o_drop_cnt    (o_drop_cnt),
    .o_reject_cnt  (o_reject_cnt),
`endif
    .o_underflow   (o_underflow)
  );

  // Reference model state
  logic [NB_DATA-1:0] mq[$];
  logic [NB_DATA-1:0] m_data;
  bit                 m_rdv, m_ovf, m_udf;
  int                 m_drop, m_rej;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [NB_DATA-1:0] obs,
                     input logic [NB_DATA-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ":count"},  NB_DATA'(o_count),        NB_DATA'(n));
    chk({tag, ":empty"},  NB_DATA'(o_empty),        NB_DATA'(n == 0));
    chk({tag, ":full"},   NB_DATA'(o_full),         NB_DATA'(n == DEPTH));
    chk({tag, ":afull"},  NB_DATA'(o_almost_full),  NB_DATA'(n >= AF_TH));
    chk({tag, ":aempty"}, NB_DATA'(o_almost_empty), NB_DATA'(n <= AE_TH));
    chk({tag, ":rdv"},    NB_DATA'(o_rd_valid),     NB_DATA'(m_rdv));
    chk({tag, ":data"},   o_data,                   m_data);
    chk({tag, ":ovf"},    NB_DATA'(o_overflow),     NB_DATA'(m_ovf));
    chk({tag, ":udf"},    NB_DATA'(o_underflow),    NB_DATA'(m_udf));
`ifdef RATE_MATCH_FIFO_ERR_CNT_EN
    chk({tag, ":dropcnt"}, NB_DATA'(o_drop_cnt),   NB_DATA'(m_drop));
    chk({tag, ":rejcnt"},  NB_DATA'(o_reject_cnt), NB_DATA'(m_rej));
`endif
  endtask

  // One clock cycle. The inputs are driven first, then the clock edge is
  // taken. After the edge, the model advances using the FIFO rules and all
  // outputs are compared.
  task automatic step(input string tag, input bit rst, input bit en, input bit vld,
                      input bit we, input bit re, input logic [NB_DATA-1:0] d);
    bit wr_req, rd_req, rd_acc, wr_acc;
    i_reset = rst; i_enable = en; i_valid = vld;
    i_write_enb = we; i_read_enb = re; i_data = d;
    @(posedge clk); #1;
    wr_req = we && vld;
    rd_req = re && vld;
    if (rst) begin
      mq.delete(); m_data = '0; m_rdv = 0; m_ovf = 0; m_udf = 0;
      m_drop = 0; m_rej = 0;
    end else if (!en) begin
      mq.delete(); m_rdv = 0;
    end else begin
      rd_acc = rd_req && (mq.size() > 0);
      wr_acc = wr_req && ((mq.size() < DEPTH) || rd_acc);
      m_rdv = rd_acc;
      if (rd_acc) m_data = mq.pop_front();
      if (wr_acc) mq.push_back(d);
      if (wr_req && !wr_acc) begin m_ovf = 1; if (m_drop < 65535) m_drop++; end
      if (rd_req && !rd_acc) begin m_udf = 1; if (m_rej < 65535) m_rej++; end
    end
    check_all(tag);
    $display("txn %-10s rst=%0d en=%0d v=%0d we=%0d re=%0d din=%h -> cnt=%0d rdv=%0d dout=%h ovf=%0d udf=%0d",
             tag, rst, en, vld, we, re, d, o_count, o_rd_valid, o_data, o_overflow, o_underflow);
  endtask

  function automatic logic [NB_DATA-1:0] rnd72();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[NB_DATA-1:0];
  endfunction

  initial begin
    logic [NB_DATA-1:0] expect_word;
    int wr_bias, rd_bias;

    // Reset state
    step("reset", 1, 1, 0, 0, 0, '0);
    step("reset", 1, 1, 0, 0, 0, '0);
    chk("reset_empty", NB_DATA'(o_empty), NB_DATA'(1'b1));
    chk("reset_aempty", NB_DATA'(o_almost_empty), NB_DATA'(1'b1));

    // Fill all 32 slots
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 0, 1, 1, 1, 0, rnd72());
      if (i == AF_TH - 2) chk("afull_before_th", NB_DATA'(o_almost_full), NB_DATA'(1'b0));
      if (i == AF_TH - 1) chk("afull_at_th", NB_DATA'(o_almost_full), NB_DATA'(1'b1));
    end
    chk("full_count32", NB_DATA'(o_count), NB_DATA'(32));
    chk("full_flag", NB_DATA'(o_full), NB_DATA'(1'b1));
    chk("full_no_ovf", NB_DATA'(o_overflow), NB_DATA'(1'b0));

    // One extra write into a full FIFO is dropped
    step("overwr", 0, 1, 1, 1, 0, rnd72());
    chk("ovf_set", NB_DATA'(o_overflow), NB_DATA'(1'b1));
    chk("ovf_count32", NB_DATA'(o_count), NB_DATA'(32));

    // Read back all 32 words in write order
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, 1, 0, 1, rnd72());
    chk("drain_empty", NB_DATA'(o_empty), NB_DATA'(1'b1));

    // Refill, then run 100 simultaneous read+write cycles with incrementing
    // data across several pointer wraps
    for (int i = 0; i < DEPTH; i++) step("refill", 0, 1, 1, 1, 0, NB_DATA'(i));
    for (int i = 0; i < 100; i++) begin
      step("fullrw", 0, 1, 1, 1, 1, NB_DATA'(DEPTH + i));
      expect_word = NB_DATA'(i);
      chk("fullrw_seq", o_data, expect_word);
    end
    chk("fullrw_count", NB_DATA'(o_count), NB_DATA'(32));
    for (int i = 0; i < DEPTH; i++) step("drain2", 0, 1, 1, 0, 1, '0);

    // Empty FIFO: a read and a write in the same cycle
    step("emptyrw", 0, 1, 1, 1, 1, 72'h1234);
    chk("emptyrw_udf", NB_DATA'(o_underflow), NB_DATA'(1'b1));
    chk("emptyrw_count", NB_DATA'(o_count), NB_DATA'(1));
    step("rd1234", 0, 1, 1, 0, 1, '0);
    chk("rd1234", o_data, 72'h1234);

    // Requests are ignored when i_valid is low
    step("w10", 0, 1, 1, 1, 0, rnd72());
    for (int i = 0; i < 4; i++) step("novalid", 0, 1, 0, 1, 1, rnd72());

    // Bring the count to 10, then disable for one cycle
    for (int i = 0; i < 9; i++) step("w10", 0, 1, 1, 1, 0, rnd72());
    chk("count10", NB_DATA'(o_count), NB_DATA'(10));
    step("disable", 0, 0, 1, 1, 1, rnd72());
    chk("disable_cnt0", NB_DATA'(o_count), NB_DATA'(0));
    chk("disable_ovf", NB_DATA'(o_overflow), NB_DATA'(1'b1));
    // After the flush, the first write must land at slot 0 and read back
    expect_word = rnd72();
    step("postdis_w", 0, 1, 1, 1, 0, expect_word);
    step("postdis_r", 0, 1, 1, 0, 1, '0);
    chk("postdis_data", o_data, expect_word);

    // Randomised traffic. The bias changes per phase to sweep through full,
    // empty and everything in between.
    for (int ph = 0; ph < 6; ph++) begin
      wr_bias = (ph % 2 == 0) ? 80 : 30;
      rd_bias = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 80; i++) begin
        step("random", 0, ($urandom_range(0, 39) != 0), ($urandom_range(0, 4) != 0),
             ($urandom_range(0, 99) < wr_bias), ($urandom_range(0, 99) < rd_bias), rnd72());
      end
    end

    // Reset clears every flag
    step("reset2", 1, 1, 1, 1, 1, rnd72());
    chk("reset2_ovf", NB_DATA'(o_overflow), NB_DATA'(1'b0));
    chk("reset2_udf", NB_DATA'(o_underflow), NB_DATA'(1'b0));
    chk("reset2_rdv", NB_DATA'(o_rd_valid), NB_DATA'(1'b0));
    chk("reset2_data", o_data, NB_DATA'(0));

`ifdef RATE_MATCH_FIFO_ERR_CNT_EN
    step("ec_rej", 0, 1, 1, 0, 1, '0);
    step("ec_rej", 0, 1, 1, 0, 1, '0);
    for (int i = 0; i < DEPTH; i++) step("ec_fill", 0, 1, 1, 1, 0, rnd72());
    for (int i = 0; i < 3; i++) step("ec_drop", 0, 1, 1, 1, 0, rnd72());
    chk("ec_drop3", NB_DATA'(o_drop_cnt), NB_DATA'(3));
    chk("ec_rej2", NB_DATA'(o_reject_cnt), NB_DATA'(2));
    // Drive 70000 drops directly so the counter saturates
    i_reset = 0; i_enable = 1; i_valid = 1; i_write_enb = 1; i_read_enb = 0;
    repeat (70000) @(posedge clk);
    #1;
    m_drop = 65535;
    chk("ec_drop_sat", NB_DATA'(o_drop_cnt), NB_DATA'(16'hFFFF));
    step("ec_after", 0, 1, 1, 1, 0, rnd72());
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
